// File: rtl/flsh_cfg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : flsh_cfg_arbiter_if / flsh_cfg_arbiter_fp_if
//  Description : Bus bundles for the flash configuration arbiter.
//                flsh_cfg_arbiter_if    - one requester's hold-until-done
//                                         command/response channel.
//                                         master = requester, slave = arbiter.
//                flsh_cfg_arbiter_fp_if - the shared downstream flash port.
//                                         master = arbiter, slave = flash.
//  Ports       : devsel[1:0], addr[13:0], wren, wdata[31:0], rden (command)
//                rdata[31:0], resp/bresp/rresp[1:0], done      (response)
//  Revision    : 1.0  initial release
// ============================================================================

interface flsh_cfg_arbiter_if;
   logic [1:0]  devsel;
   logic [13:0] addr;
   logic        wren;
   logic [31:0] wdata;
   logic        rden;
   logic [31:0] rdata;
   logic [1:0]  resp;
   logic        done;

   modport master (output devsel, addr, wren, wdata, rden,
                   input  rdata, resp, done);
   modport slave  (input  devsel, addr, wren, wdata, rden,
                   output rdata, resp, done);
endinterface

interface flsh_cfg_arbiter_fp_if;
   logic [1:0]  devsel;
   logic [13:0] addr;
   logic        wren;
   logic [31:0] wdata;
   logic        rden;
   logic [31:0] rdata;
   logic        done;
   logic [1:0]  bresp;
   logic [1:0]  rresp;

   modport master (output devsel, addr, wren, wdata, rden,
                   input  rdata, done, bresp, rresp);
   modport slave  (input  devsel, addr, wren, wdata, rden,
                   output rdata, done, bresp, rresp);
endinterface

`default_nettype wire

// File: rtl/flsh_cfg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : flsh_cfg_arbiter
//  Description : Round-robin arbiter sharing one hold-until-done flash config
//                port between the host register interface (req0) and the
//                maintenance engine (req1). The granted command is registered
//                and held until the slave completes or a timeout forces an
//                SLVERR completion.
//  Ports       : clock_afu, reset_afu_n  - clock, async active-low reset
//                req0, req1              - requester channels (slave modport)
//                flsh                    - downstream flash port (master)
//                arb_busy                - arbiter not idle
//                arb_owner               - current / last granted requester
//                arb_timeout_err         - one-cycle forced-timeout pulse
//  Revision    : 1.0  initial release
// ============================================================================

module flsh_cfg_arbiter #(
   parameter int TIMEOUT_CYCLES = 4095,
   parameter int TO_W           = 12
) (
   input  logic                  clock_afu,
   input  logic                  reset_afu_n,
   flsh_cfg_arbiter_if.slave     req0,
   flsh_cfg_arbiter_if.slave     req1,
   flsh_cfg_arbiter_fp_if.master flsh,
   output logic                  arb_busy,
   output logic                  arb_owner,
   output logic                  arb_timeout_err
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_REL1 = 2'd2,
      ST_REL2 = 2'd3
   } state_t;

   state_t            state_q,  state_d;
   logic [1:0]        devsel_q, devsel_d;
   logic [13:0]       addr_q,   addr_d;
   logic [31:0]       wdata_q,  wdata_d;
   logic              wren_q,   wren_d;
   logic              rden_q,   rden_d;
   logic              owner_q,  owner_d;
   logic              last_q,   last_d;
   logic [TO_W-1:0]   cnt_q,    cnt_d;
   logic [31:0]       rdata_q,  rdata_d;
   logic [1:0]        resp_q,   resp_d;
   logic              to_q,     to_d;

   logic              req0_v;
   logic              req1_v;
   logic              gnt;
   logic              sel_wren;
   logic [1:0]        sel_devsel;
   logic [13:0]       sel_addr;
   logic [31:0]       sel_wdata;

   assign req0_v = req0.wren | req0.rden;
   assign req1_v = req1.wren | req1.rden;

   // On a tie the requester that did not win last time gets the port.
   assign gnt        = (req0_v & req1_v) ? ~last_q : req1_v;
   assign sel_wren   = gnt ? req1.wren   : req0.wren;
   assign sel_devsel = gnt ? req1.devsel : req0.devsel;
   assign sel_addr   = gnt ? req1.addr   : req0.addr;
   assign sel_wdata  = gnt ? req1.wdata  : req0.wdata;

   always_ff @(posedge clock_afu or negedge reset_afu_n) begin
      if (!reset_afu_n) begin
         state_q  <= ST_IDLE;
         devsel_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wren_q   <= 1'b0;
         rden_q   <= 1'b0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         rdata_q  <= '0;
         resp_q   <= '0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         devsel_q <= devsel_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wren_q   <= wren_d;
         rden_q   <= rden_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         resp_q   <= resp_d;
         to_q     <= to_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      devsel_d = devsel_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wren_d   = wren_q;
      rden_d   = rden_q;
      owner_d  = owner_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      resp_d   = resp_q;
      to_d     = to_q;

      case (state_q)
         ST_IDLE: begin
            if (req0_v | req1_v) begin
               devsel_d = sel_devsel;
               addr_d   = sel_addr;
               wdata_d  = sel_wdata;
               // A request with both enables set is issued as a write.
               wren_d   = sel_wren;
               rden_d   = ~sel_wren;
               owner_d  = gnt;
               last_d   = gnt;
               cnt_d    = '0;
               // Clear the result so the new owner never sees stale data.
               rdata_d  = '0;
               resp_d   = '0;
               to_d     = 1'b0;
               state_d  = ST_WAIT;
            end
         end

         ST_WAIT: begin
            cnt_d = cnt_q + TO_W'(1);
            // Slave completion takes priority over a coincident timeout.
            if (flsh.done) begin
               rdata_d = wren_q ? 32'h0 : flsh.rdata;
               resp_d  = wren_q ? flsh.bresp : flsh.rresp;
               to_d    = 1'b0;
               wren_d  = 1'b0;
               rden_d  = 1'b0;
               state_d = ST_REL1;
            end else if (cnt_q == TO_LAST) begin
               rdata_d = 32'hFFFF_FFFF;
               resp_d  = 2'b10;
               to_d    = 1'b1;
               wren_d  = 1'b0;
               rden_d  = 1'b0;
               state_d = ST_REL1;
            end
         end

         ST_REL1: state_d = ST_REL2;

         // Dead cycle: owner drops its request, slave sees enables low.
         ST_REL2: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   assign flsh.devsel = devsel_q;
   assign flsh.addr   = addr_q;
   assign flsh.wdata  = wdata_q;
   assign flsh.wren   = wren_q;
   assign flsh.rden   = rden_q;

   assign req0.done  = (state_q == ST_REL1) & ~owner_q;
   assign req0.rdata = owner_q ? 32'h0 : rdata_q;
   assign req0.resp  = owner_q ? 2'b00 : resp_q;
   assign req1.done  = (state_q == ST_REL1) &  owner_q;
   assign req1.rdata = owner_q ? rdata_q : 32'h0;
   assign req1.resp  = owner_q ? resp_q  : 2'b00;

   assign arb_busy        = (state_q != ST_IDLE);
   assign arb_owner       = owner_q;
   assign arb_timeout_err = (state_q == ST_REL1) & to_q;

endmodule

`default_nettype wire

// File: tb/tb_flsh_cfg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flsh_cfg_arbiter
//  Description : Directed self-checking bench for flsh_cfg_arbiter with
//                TIMEOUT_CYCLES=8. A small flash-slave model answers after a
//                programmable number of enabled cycles, or never when muted.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_flsh_cfg_arbiter;

   logic clock_afu = 1'b0;
   logic reset_afu_n;
   logic arb_busy;
   logic arb_owner;
   logic arb_timeout_err;

   always #5 clock_afu = ~clock_afu;

   flsh_cfg_arbiter_if    r0 ();
   flsh_cfg_arbiter_if    r1 ();
   flsh_cfg_arbiter_fp_if fp ();

   flsh_cfg_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
      .clock_afu       (clock_afu),
      .reset_afu_n     (reset_afu_n),
      .req0            (r0),
      .req1            (r1),
      .flsh            (fp),
      .arb_busy        (arb_busy),
      .arb_owner       (arb_owner),
      .arb_timeout_err (arb_timeout_err)
   );

   int          checks = 0;
   int          errors = 0;
   int          slv_lat = 5;
   bit          slv_mute = 1'b0;
   bit          slv_force = 1'b0;
   logic [31:0] slv_rdata = 32'h0;
   logic [1:0]  slv_bresp = 2'b00;
   logic [1:0]  slv_rresp = 2'b00;
   int          slv_cnt = 0;

   // One clock: advance past the edge, then update the slave model, which
   // asserts done on the slv_lat-th consecutive enabled cycle.
   task automatic step();
      @(posedge clock_afu);
      #1;
      if (fp.wren | fp.rden) slv_cnt++;
      else                   slv_cnt = 0;
      fp.done  = slv_force | (!slv_mute && (fp.wren | fp.rden) && slv_cnt == slv_lat);
      fp.rdata = slv_rdata;
      fp.bresp = slv_bresp;
      fp.rresp = slv_rresp;
   endtask

   task automatic idle_r0();
      r0.devsel = 2'b00; r0.addr = 14'h0; r0.wren = 1'b0; r0.wdata = 32'h0; r0.rden = 1'b0;
   endtask

   task automatic idle_r1();
      r1.devsel = 2'b00; r1.addr = 14'h0; r1.wren = 1'b0; r1.wdata = 32'h0; r1.rden = 1'b0;
   endtask

   task automatic apply_reset();
      idle_r0();
      idle_r1();
      slv_mute = 1'b0;
      slv_force = 1'b0;
      reset_afu_n = 1'b0;
      step();
      step();
      reset_afu_n = 1'b1;
   endtask

   task automatic wait_done(input bit who, input int budget, output int n, output int en);
      n = 0;
      en = 0;
      while (n < budget) begin
         step();
         n++;
         if (fp.wren | fp.rden) en++;
         if ((who == 1'b0 && r0.done === 1'b1) || (who == 1'b1 && r1.done === 1'b1)) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_done_req%0d: no done within %0d cycles", who, budget);
   endtask

   task automatic test_reset();
      idle_r0();
      idle_r1();
      reset_afu_n = 1'b0;
      #2;
      checks++;
      if ({fp.wren, fp.rden, fp.devsel, fp.addr, fp.wdata} !== 50'h0) begin
         errors++; $display("FAIL reset_fp_cmd: got %h want 0", {fp.wren, fp.rden, fp.devsel, fp.addr, fp.wdata});
      end
      checks++;
      if ({arb_busy, arb_owner, arb_timeout_err} !== 3'b000) begin
         errors++; $display("FAIL reset_status: got %b want 000", {arb_busy, arb_owner, arb_timeout_err});
      end
      checks++;
      if ({r0.done, r1.done, r0.resp, r1.resp, r0.rdata, r1.rdata} !== 70'h0) begin
         errors++; $display("FAIL reset_req_outputs: got %h want 0", {r0.done, r1.done, r0.resp, r1.resp, r0.rdata, r1.rdata});
      end
      step();
      reset_afu_n = 1'b1;
      step();
      checks++;
      if (arb_busy !== 1'b0) begin
         errors++; $display("FAIL reset_idle_no_req: busy got %b want 0", arb_busy);
      end
   endtask

   task automatic test_read();
      int n;
      int en;
      int bad_stable;
      int bad_r1;
      slv_lat = 5; slv_rdata = 32'hA5A5_0001; slv_rresp = 2'b00; slv_bresp = 2'b11;
      r0.devsel = 2'd1; r0.addr = 14'h0123; r0.rden = 1'b1;
      step();
      checks++;
      if ({fp.rden, fp.wren, fp.devsel, fp.addr, arb_owner, arb_busy} !== {1'b1, 1'b0, 2'd1, 14'h0123, 1'b0, 1'b1}) begin
         errors++; $display("FAIL read_grant: rden=%b wren=%b devsel=%0d addr=%h owner=%b busy=%b want 1 0 1 0123 0 1",
                            fp.rden, fp.wren, fp.devsel, fp.addr, arb_owner, arb_busy);
      end
      n = 1; en = 1; bad_stable = 0; bad_r1 = 0;
      while (r0.done !== 1'b1 && n < 20) begin
         step();
         n++;
         if (fp.rden) begin
            en++;
            if (fp.devsel !== 2'd1 || fp.addr !== 14'h0123) bad_stable++;
         end
         if (r1.done !== 1'b0) bad_r1++;
      end
      checks++;
      if (en !== 5 || n !== 6) begin
         errors++; $display("FAIL read_latency: rden cycles %0d done after %0d want 5 and 6", en, n);
      end
      checks++;
      if (bad_stable !== 0) begin
         errors++; $display("FAIL read_cmd_stable: %0d unstable cycles want 0", bad_stable);
      end
      checks++;
      if (r0.rdata !== 32'hA5A5_0001 || r0.resp !== 2'b00 || fp.rden !== 1'b0) begin
         errors++; $display("FAIL read_result: rdata=%h resp=%b rden=%b want a5a50001 00 0", r0.rdata, r0.resp, fp.rden);
      end
      checks++;
      if (bad_r1 !== 0 || r1.done !== 1'b0 || r1.rdata !== 32'h0 || arb_timeout_err !== 1'b0) begin
         errors++; $display("FAIL read_nonowner: r1 done seen %0d rdata=%h toerr=%b want 0 0 0", bad_r1, r1.rdata, arb_timeout_err);
      end
      idle_r0();
      step();
      checks++;
      if (r0.done !== 1'b0 || arb_busy !== 1'b1 || fp.rden !== 1'b0) begin
         errors++; $display("FAIL read_rel2: done=%b busy=%b rden=%b want 0 1 0", r0.done, arb_busy, fp.rden);
      end
      step();
      checks++;
      if (arb_busy !== 1'b0) begin
         errors++; $display("FAIL read_back_idle: busy got %b want 0", arb_busy);
      end
   endtask

   task automatic test_tie();
      int n;
      int en;
      apply_reset();
      slv_lat = 3; slv_bresp = 2'b01; slv_rresp = 2'b00; slv_rdata = 32'h1234_5678;
      r0.wren = 1'b1; r0.wdata = 32'hDEAD_BEEF; r0.devsel = 2'd2; r0.addr = 14'h3FFF;
      r1.rden = 1'b1; r1.devsel = 2'd3; r1.addr = 14'h0042;
      step();
      checks++;
      if ({fp.wren, fp.rden, fp.wdata, fp.devsel, fp.addr, arb_owner} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 2'd2, 14'h3FFF, 1'b0}) begin
         errors++; $display("FAIL tie_first_grant: wren=%b rden=%b wdata=%h devsel=%0d addr=%h owner=%b want 1 0 deadbeef 2 3fff 0",
                            fp.wren, fp.rden, fp.wdata, fp.devsel, fp.addr, arb_owner);
      end
      wait_done(1'b0, 20, n, en);
      checks++;
      if (r0.resp !== 2'b01 || r0.rdata !== 32'h0 || r1.done !== 1'b0) begin
         errors++; $display("FAIL tie_write_result: resp=%b rdata=%h r1done=%b want 01 0 0", r0.resp, r0.rdata, r1.done);
      end
      idle_r0();
      step();
      step();
      checks++;
      if (fp.rden !== 1'b0 || arb_owner !== 1'b0) begin
         errors++; $display("FAIL tie_gap: rden=%b owner=%b want 0 0", fp.rden, arb_owner);
      end
      step();
      checks++;
      if ({fp.rden, fp.wren, fp.devsel, fp.addr, arb_owner} !== {1'b1, 1'b0, 2'd3, 14'h0042, 1'b1}) begin
         errors++; $display("FAIL tie_second_grant: rden=%b wren=%b devsel=%0d addr=%h owner=%b want 1 0 3 0042 1",
                            fp.rden, fp.wren, fp.devsel, fp.addr, arb_owner);
      end
      wait_done(1'b1, 20, n, en);
      checks++;
      if (r1.rdata !== 32'h1234_5678 || r1.resp !== 2'b00 || r0.done !== 1'b0 || r0.rdata !== 32'h0) begin
         errors++; $display("FAIL tie_read_result: r1 rdata=%h resp=%b r0 done=%b rdata=%h want 12345678 00 0 0",
                            r1.rdata, r1.resp, r0.done, r0.rdata);
      end
      idle_r1();
      step();
      step();
   endtask

   task automatic test_back_to_back();
      logic got [4];
      int   k = 0;
      int   dones = 0;
      int   issued = 2;
      int   cyc = 0;
      int   t_first = -1;
      int   t_second = -1;
      bit   prev_en = 1'b0;
      bit   re0 = 1'b0;
      bit   re1 = 1'b0;
      for (int i = 0; i < 4; i++) got[i] = 1'bx;
      apply_reset();
      slv_lat = 2; slv_rdata = 32'h0000_0BB0; slv_rresp = 2'b00; slv_bresp = 2'b00;
      r0.rden = 1'b1; r0.addr = 14'h0010;
      r1.wren = 1'b1; r1.addr = 14'h0020; r1.wdata = 32'h0000_0020;
      while (dones < 4 && cyc < 200) begin
         step();
         cyc++;
         if (re0) begin r0.rden = 1'b1; re0 = 1'b0; end
         if (re1) begin r1.wren = 1'b1; re1 = 1'b0; end
         if ((fp.wren | fp.rden) && !prev_en && k < 4) begin
            got[k] = arb_owner;
            if (k == 0) t_first = cyc;
            if (k == 1) t_second = cyc;
            k++;
         end
         prev_en = fp.wren | fp.rden;
         if (r0.done === 1'b1) begin
            dones++; r0.rden = 1'b0;
            if (issued < 4) begin re0 = 1'b1; issued++; end
         end
         if (r1.done === 1'b1) begin
            dones++; r1.wren = 1'b0;
            if (issued < 4) begin re1 = 1'b1; issued++; end
         end
      end
      checks++;
      if (dones !== 4) begin
         errors++; $display("FAIL b2b_done_count: got %0d want 4", dones);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got[i] !== i[0]) begin
            errors++; $display("FAIL b2b_grant_order[%0d]: got %b want %b", i, got[i], i[0]);
         end
      end
      checks++;
      if (t_second - t_first !== 5) begin
         errors++; $display("FAIL b2b_grant_spacing: got %0d cycles want 5", t_second - t_first);
      end
      step();
      step();
   endtask

   task automatic test_timeout();
      int n;
      int en;
      int bad = 0;
      slv_mute = 1'b1;
      r1.rden = 1'b1; r1.devsel = 2'd0; r1.addr = 14'h0777;
      wait_done(1'b1, 30, n, en);
      checks++;
      if (en !== 8 || n !== 9) begin
         errors++; $display("FAIL timeout_length: enable cycles %0d done after %0d want 8 and 9", en, n);
      end
      checks++;
      if (r1.rdata !== 32'hFFFF_FFFF || r1.resp !== 2'b10 || arb_timeout_err !== 1'b1 || fp.rden !== 1'b0 || r0.done !== 1'b0) begin
         errors++; $display("FAIL timeout_result: rdata=%h resp=%b toerr=%b rden=%b r0done=%b want ffffffff 10 1 0 0",
                            r1.rdata, r1.resp, arb_timeout_err, fp.rden, r0.done);
      end
      idle_r1();
      step();
      checks++;
      if (arb_timeout_err !== 1'b0 || r1.done !== 1'b0) begin
         errors++; $display("FAIL timeout_pulse_width: toerr=%b done=%b want 0 0", arb_timeout_err, r1.done);
      end
      step();
      slv_force = 1'b1;
      step();
      slv_force = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (r0.done !== 1'b0 || r1.done !== 1'b0 || arb_busy !== 1'b0 || arb_timeout_err !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL timeout_late_done: %0d disturbed cycles want 0", bad);
      end
      slv_mute = 1'b0;
   endtask

   task automatic test_done_at_last();
      int n;
      int en;
      slv_lat = 8; slv_bresp = 2'b00; slv_rresp = 2'b11; slv_rdata = 32'h5555_5555;
      r0.wren = 1'b1; r0.rden = 1'b1; r0.wdata = 32'hCAFE_F00D; r0.addr = 14'h0ABC;
      step();
      checks++;
      if (fp.wren !== 1'b1 || fp.rden !== 1'b0 || fp.wdata !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL both_en_is_write: wren=%b rden=%b wdata=%h want 1 0 cafef00d", fp.wren, fp.rden, fp.wdata);
      end
      wait_done(1'b0, 30, n, en);
      checks++;
      if (en + 1 !== 8 || n !== 8) begin
         errors++; $display("FAIL last_cycle_len: enable cycles %0d done after %0d want 8 and 8", en + 1, n);
      end
      checks++;
      if (r0.resp !== 2'b00 || r0.rdata !== 32'h0 || arb_timeout_err !== 1'b0) begin
         errors++; $display("FAIL last_cycle_done_wins: resp=%b rdata=%h toerr=%b want 00 0 0", r0.resp, r0.rdata, arb_timeout_err);
      end
      idle_r0();
      step();
      step();
   endtask

   task automatic test_reset_mid();
      int n;
      int en;
      int bad = 0;
      slv_mute = 1'b1;
      r1.rden = 1'b1; r1.devsel = 2'd1; r1.addr = 14'h0222;
      step();
      step();
      step();
      checks++;
      if (fp.rden !== 1'b1 || arb_owner !== 1'b1) begin
         errors++; $display("FAIL rstmid_setup: rden=%b owner=%b want 1 1", fp.rden, arb_owner);
      end
      #1;
      reset_afu_n = 1'b0;
      #1;
      checks++;
      if ({fp.rden, fp.wren, fp.addr, arb_busy, arb_owner, r1.done} !== 19'h0) begin
         errors++; $display("FAIL rstmid_async_clear: rden=%b addr=%h busy=%b owner=%b done=%b want all 0",
                            fp.rden, fp.addr, arb_busy, arb_owner, r1.done);
      end
      r0.rden = 1'b1; r0.devsel = 2'd2; r0.addr = 14'h0111;
      for (int i = 0; i < 2; i++) begin
         step();
         if (r0.done !== 1'b0 || r1.done !== 1'b0 || fp.rden !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL rstmid_no_done: %0d bad cycles want 0", bad);
      end
      slv_mute = 1'b0; slv_lat = 2; slv_rdata = 32'h0BAD_F00D; slv_rresp = 2'b01;
      reset_afu_n = 1'b1;
      step();
      checks++;
      if (fp.rden !== 1'b1 || arb_owner !== 1'b0 || fp.addr !== 14'h0111) begin
         errors++; $display("FAIL rstmid_regrant: rden=%b owner=%b addr=%h want 1 0 0111", fp.rden, arb_owner, fp.addr);
      end
      wait_done(1'b0, 20, n, en);
      checks++;
      if (r0.rdata !== 32'h0BAD_F00D || r0.resp !== 2'b01 || r1.done !== 1'b0) begin
         errors++; $display("FAIL rstmid_r0_result: rdata=%h resp=%b r1done=%b want 0badf00d 01 0", r0.rdata, r0.resp, r1.done);
      end
      idle_r0();
      wait_done(1'b1, 20, n, en);
      checks++;
      if (r1.rdata !== 32'h0BAD_F00D || arb_owner !== 1'b1) begin
         errors++; $display("FAIL rstmid_r1_result: rdata=%h owner=%b want 0badf00d 1", r1.rdata, arb_owner);
      end
      idle_r1();
      step();
      step();
   endtask

   initial begin
      reset_afu_n = 1'b0;
      fp.done = 1'b0; fp.rdata = 32'h0; fp.bresp = 2'b00; fp.rresp = 2'b00;
      idle_r0();
      idle_r1();
      test_reset();
      test_read();
      test_tie();
      test_back_to_back();
      test_timeout();
      test_done_at_last();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/flsh_cfg_arbiter.md
Name: flsh_cfg_arbiter

Overview:
- Shares the single hold-until-done flash configuration port (cfg_flsh_* / flsh_cfg_*) between two requesters:
  - req0: host config-space register interface.
  - req1: on-card maintenance engine (boot image check, status polling).
- Grants round-robin and registers the granted command so the downstream port sees it held stable until done.
- Returns the result and a one-cycle done to the owner, and enforces a completion timeout so a hung slave cannot lock out either requester.

Parameters:
TIMEOUT_CYCLES, 4095, max cycles in WAIT before forced error completion (>=2)
TO_W, 12, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clock_afu  in  1  sole clock
reset_afu_n  in  1  asynchronous active-low reset
reqN_devsel  in  2  (N=0,1) target AXI4-Lite slave select
reqN_addr  in  14  target address
reqN_wren  in  1  write request, held until reqN_done
reqN_wdata  in  32  write data
reqN_rden  in  1  read request, held until reqN_done
reqN_rdata  out  32  read result, valid with reqN_done
reqN_resp  out  2  bresp (write) or rresp (read), valid with reqN_done
reqN_done  out  1  one-cycle completion pulse
cfg_flsh_devsel  out  2  to flash port
cfg_flsh_addr  out  14  to flash port
cfg_flsh_wren  out  1  to flash port
cfg_flsh_wdata  out  32  to flash port
cfg_flsh_rden  out  1  to flash port
flsh_cfg_rdata  in  32  from flash port
flsh_cfg_done  in  1  from flash port
flsh_cfg_bresp  in  2  from flash port
flsh_cfg_rresp  in  2  from flash port
arb_busy  out  1  state != IDLE
arb_owner  out  1  index of current or last grant
arb_timeout_err  out  1  one-cycle pulse on forced timeout completion

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Round-robin pointer last=1, so req0 wins the first tie.
  - Reset mid-operation aborts the command with no done pulse; the downstream enables drop immediately.
- Request valid: reqN_v = reqN_wren | reqN_rden. If both enables are set, the request is treated as a write; the downstream port sees wren=1, rden=0.
- IDLE:
  - Neither valid: stay.
  - One valid: grant it.
  - Both valid: grant ~last.
  - On grant: register devsel/addr/wdata/is_write into the output regs, assert the matching cfg_flsh_wren or cfg_flsh_rden, set arb_owner and last, clear the timeout counter, go to WAIT.
  - First downstream enable appears 1 cycle after the request is first seen.
- WAIT:
  - Output registers are held constant; requester inputs are ignored, including withdrawal mid-operation. A withdrawn command still completes and pulses done.
  - Counter increments each cycle.
  - flsh_cfg_done=1: capture rdata (0 for writes) and resp (bresp if write, else rresp), go to REL1.
  - Counter reaches TIMEOUT_CYCLES-1 with no done: load rdata=32'hFFFF_FFFF, resp=2'b10 (SLVERR), go to REL1.
  - Done and timeout in the same cycle: done wins, no error.
- REL1:
  - Downstream enables = 0; owner's reqN_done = 1 with rdata/resp valid.
  - arb_timeout_err = 1 if entered by timeout.
  - Go to REL2.
- REL2:
  - Enables stay 0; no done.
  - Lets the owner drop its request and gives the slave a low cycle between commands. Go to IDLE.
- Requester rule: the requester deasserts wren/rden in the cycle after reqN_done. A request still asserted in IDLE is a new command.
- flsh_cfg_done outside WAIT (late response after timeout) is ignored.
- Only the owner's done/rdata/resp change; the non-owner's outputs hold 0.
- Throughput: back-to-back from different requesters = slave latency + 3 cycles overhead.

Test Plan:
- req0 read devsel=1 addr=0x0123; slave done after 5 cycles with rdata=0xA5A5_0001, rresp=0 -> cfg_flsh_rden=1 stable for 5 cycles; req0_done pulses 1 cycle later with that data and resp=0; req1_done stays 0.
- req0 write and req1 read both raised in the same cycle after reset -> req0 granted first (wren, wdata passed through); req1 granted 2 cycles after req0_done; arb_owner 0 then 1.
- Both requesters continuously re-requesting for 4 transactions -> grants alternate 0,1,0,1.
- TIMEOUT_CYCLES=8, slave never responds -> enable drops after 8 WAIT cycles; req1_done with rdata=0xFFFF_FFFF, resp=2'b10, arb_timeout_err pulse. A late flsh_cfg_done 3 cycles later is ignored.
- Slave done on exactly the last timeout cycle with bresp=2'b00 -> normal completion, resp=0, no arb_timeout_err.
- reset_afu_n asserted during WAIT -> all outputs 0 asynchronously, no done pulse. After release a pending req0 and req1 -> req0 granted first.
